// File: rtl/switch_port.sv
// Switch input port: synchronises and debounces board switches, holds a stable
// word for the CPU and flags changes (new_data) and missed changes (overrun).
module switch_port #(
  parameter int unsigned WORD_W    = 8,
  parameter int unsigned OP_W      = 3,
  parameter int unsigned DEB_W     = 4,
  parameter int unsigned DATA_ADDR = 2**(WORD_W-OP_W)-1,
  parameter int unsigned STAT_ADDR = 2**(WORD_W-OP_W)-3
) (
  input  logic                     clock,
  input  logic                     n_reset,
  input  logic [WORD_W-1:0]        switches,
  input  logic [WORD_W-OP_W-1:0]   Daddress,
  input  logic                     rd_strobe,
  output logic [WORD_W-1:0]        Sdata,
  output logic                     new_data,
  output logic                     overrun
);

  localparam int unsigned ADDR_W = WORD_W - OP_W;
  localparam logic [ADDR_W-1:0] DATA_A  = ADDR_W'(DATA_ADDR);
  localparam logic [ADDR_W-1:0] STAT_A  = ADDR_W'(STAT_ADDR);
  localparam logic [DEB_W-1:0]  CNT_MAX = {DEB_W{1'b1}};

  logic [WORD_W-1:0] sync1_q, sync1_d;
  logic [WORD_W-1:0] sync2_q, sync2_d;
  logic [WORD_W-1:0] cand_q, cand_d;
  logic [WORD_W-1:0] stable_q, stable_d;
  logic [DEB_W-1:0]  cnt_q, cnt_d;
  logic              new_data_q, new_data_d;
  logic              overrun_q, overrun_d;

  logic update_c;
  logic rd_data_c;
  logic rd_stat_c;

  // A candidate is accepted once it has been seen steady for the full window.
  assign update_c  = (sync2_q == cand_q) && (cnt_q == CNT_MAX) && (cand_q != stable_q);
  assign rd_data_c = rd_strobe && (Daddress == DATA_A);
  assign rd_stat_c = rd_strobe && (Daddress == STAT_A);

  always_comb begin
    sync1_d    = switches;
    sync2_d    = sync1_q;
    cand_d     = cand_q;
    cnt_d      = cnt_q;
    stable_d   = stable_q;
    new_data_d = new_data_q;
    overrun_d  = overrun_q;

    if (sync2_q != cand_q) begin
      cand_d = sync2_q;
      cnt_d  = '0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + DEB_W'(1);
    end

    if (update_c) begin
      stable_d = cand_q;
    end

    // Set beats clear so a change landing on a read edge is never lost.
    if (update_c) begin
      new_data_d = 1'b1;
    end else if (rd_data_c) begin
      new_data_d = 1'b0;
    end

    if (update_c && new_data_q) begin
      overrun_d = 1'b1;
    end else if (rd_stat_c) begin
      overrun_d = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      cand_q     <= '0;
      cnt_q      <= '0;
      stable_q   <= '0;
      new_data_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      cand_q     <= cand_d;
      cnt_q      <= cnt_d;
      stable_q   <= stable_d;
      new_data_q <= new_data_d;
      overrun_q  <= overrun_d;
    end
  end

  always_comb begin
    Sdata = '0;
    if (Daddress == DATA_A) begin
      Sdata = stable_q;
    end else if (Daddress == STAT_A) begin
      Sdata = {{(WORD_W-2){1'b0}}, overrun_q, new_data_q};
    end
  end

  assign new_data = new_data_q;
  assign overrun  = overrun_q;

endmodule
